canny_non_max_suppress: RTL and testbench



---
 rtl/canny_non_max_suppress.sv | 173 +++++++++++++++++
 tb/tb_canny_non_max_suppress.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/canny_non_max_suppress.sv
// Canny non-maximum suppression: 3x3 gradient window built from two cascaded
// line buffers; the centre word survives only if it is a local maximum along its direction.
`timescale 1ns/1ps
module canny_non_max_suppress #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst_s,
   input  logic        grandient_hs,
   input  logic        grandient_vs,
   input  logic        grandient_de,
   input  logic [15:0] gra_path,
   output logic        nms_hs,
   output logic        nms_vs,
   output logic        nms_de,
   output logic [15:0] nms_path
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic          hs_d, vs_d, active;
   logic [CW-1:0] col;
   logic          col_full;
   logic [RW-1:0] row;

   logic          hs_rise, hs_fall, vs_rise, run;
   logic          de_in, hs_in, vs_in, wr_en, first_col;
   logic [CW-1:0] col_eff;
   logic          full_eff;
   logic [RW-1:0] row_eff;
   logic [15:0]   rd0, rd1, tap23, tap33;

   logic [15:0]   lb0 [IMG_WIDTH];
   logic [15:0]   lb1 [IMG_WIDTH];

   logic [15:0]   p11, p12, p13, p21, p22, p23, p31, p32, p33;
   logic          fz1;

   logic [9:0]    sel_a, sel_b, a2, b2;
   logic          sel_ok, ok2;
   logic [15:0]   cen2;

   logic [2:0]    hs_sr, vs_sr, de_sr;

   // vs_d resets high so a frame already in progress at reset release is not
   // mistaken for a new frame; output stays silent until a genuine vs rise.
   always_comb begin
      vs_rise   = grandient_vs & ~vs_d;
      run       = active | vs_rise;
      hs_rise   = grandient_hs & ~hs_d;
      hs_fall   = ~grandient_hs & hs_d;
      de_in     = grandient_de & run;
      hs_in     = grandient_hs & run;
      vs_in     = grandient_vs & run;
      col_eff   = hs_rise ? '0 : col;
      full_eff  = hs_rise ? 1'b0 : col_full;
      row_eff   = vs_rise ? '0 : row;
      wr_en     = de_in & ~full_eff;
      first_col = (col_eff == '0);
      rd0       = lb0[col_eff];
      rd1       = lb1[col_eff];
      tap23     = (row_eff != '0)     ? rd0 : 16'd0;
      tap33     = (row_eff > RW'(1))  ? rd1 : 16'd0;
   end

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         hs_d     <= 1'b0;
         vs_d     <= 1'b1;
         active   <= 1'b0;
         col      <= '0;
         col_full <= 1'b0;
         row      <= '0;
      end else begin
         hs_d <= grandient_hs;
         vs_d <= grandient_vs;
         if (vs_rise)
            active <= 1'b1;
         if (de_in) begin
            col_full <= full_eff | (col_eff == COL_LAST);
            col      <= (col_eff == COL_LAST) ? col_eff : col_eff + CW'(1);
         end else if (hs_rise) begin
            col      <= '0;
            col_full <= 1'b0;
         end
         if (vs_rise)
            row <= '0;
         else if (run && hs_fall && row != ROW_LAST)
            row <= row + RW'(1);
      end
   end

   // Line buffers carry no reset so they map onto RAM; stale lines are masked by the row count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         lb0[col_eff] <= gra_path;
         lb1[col_eff] <= rd0;
      end
   end

   // Stage 1: window shift; columns left of col 0 enter as zero.
   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         p11 <= '0; p12 <= '0; p13 <= '0;
         p21 <= '0; p22 <= '0; p23 <= '0;
         p31 <= '0; p32 <= '0; p33 <= '0;
         fz1 <= 1'b0;
      end else if (de_in) begin
         p13 <= gra_path;
         p12 <= first_col ? 16'd0 : p13;
         p11 <= first_col ? 16'd0 : p12;
         p23 <= tap23;
         p22 <= first_col ? 16'd0 : p23;
         p21 <= first_col ? 16'd0 : p22;
         p33 <= tap33;
         p32 <= first_col ? 16'd0 : p33;
         p31 <= first_col ? 16'd0 : p32;
         fz1 <= (row_eff == '0) | first_col | full_eff;
      end
   end

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_ok = 1'b0;
      case (p22[13:10])
         4'b0001: begin sel_a = p21[9:0]; sel_b = p23[9:0]; sel_ok = 1'b1; end
         4'b0100: begin sel_a = p12[9:0]; sel_b = p32[9:0]; sel_ok = 1'b1; end
         4'b0010: begin sel_a = p13[9:0]; sel_b = p31[9:0]; sel_ok = 1'b1; end
         4'b1000: begin sel_a = p11[9:0]; sel_b = p33[9:0]; sel_ok = 1'b1; end
         default: sel_ok = 1'b0;
      endcase
      if (fz1)
         sel_ok = 1'b0;
   end

   // Stage 2 runs freely; stage 3 only samples it when the delayed de says it holds a pixel.
   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         a2       <= '0;
         b2       <= '0;
         ok2      <= 1'b0;
         cen2     <= '0;
         nms_path <= '0;
         hs_sr    <= '0;
         vs_sr    <= '0;
         de_sr    <= '0;
      end else begin
         a2    <= sel_a;
         b2    <= sel_b;
         ok2   <= sel_ok;
         cen2  <= p22;
         hs_sr <= {hs_sr[1:0], hs_in};
         vs_sr <= {vs_sr[1:0], vs_in};
         de_sr <= {de_sr[1:0], de_in};
         if (de_sr[1]) begin
            if (ok2 && cen2[9:0] != 10'd0 && cen2[9:0] >= a2 && cen2[9:0] >= b2)
               nms_path <= cen2;
            else
               nms_path <= 16'd0;
         end
      end
   end

   assign nms_hs = hs_sr[2];
   assign nms_vs = vs_sr[2];
   assign nms_de = de_sr[2];

endmodule

// File: tb/tb_canny_non_max_suppress.sv
// Self-checking bench for canny_non_max_suppress on a 5x5 frame: expected words
// are queued at stimulus time and popped by a monitor whenever nms_de is seen.
`timescale 1ns/1ps
module tb_canny_non_max_suppress;

   localparam int W = 5;
   localparam int H = 5;

   typedef struct {
      logic [15:0] val;
      bit          care;
   } exp_t;

   logic        clk, rst_s, hs, vs, de;
   logic [15:0] gp;
   logic        nms_hs, nms_vs, nms_de;
   logic [15:0] nms_path;

   int   checks   = 0;
   int   failures = 0;
   bit   frame_on = 1'b0;
   exp_t q[$];
   logic [2:0]  hist;
   logic [15:0] img [H][W];

   canny_non_max_suppress #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst_s(rst_s),
      .grandient_hs(hs), .grandient_vs(vs), .grandient_de(de), .gra_path(gp),
      .nms_hs(nms_hs), .nms_vs(nms_vs), .nms_de(nms_de), .nms_path(nms_path)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference delay line for the strobe: only pixels of a frame the DUT should accept.
   always @(posedge clk or negedge rst_s) begin
      if (!rst_s) hist <= '0;
      else        hist <= {hist[1:0], de & frame_on};
   end

   // Monitor: timing of nms_de, then scoreboard pop on every output pixel.
   always @(negedge clk) begin
      if (rst_s) begin
         if (nms_de || hist[2]) begin
            checks++;
            if (nms_de !== hist[2]) begin
               failures++;
               $display("[TB] FAIL de_latency t=%0t actual=%b expected=%b", $time, nms_de, hist[2]);
            end
         end
         if (nms_de === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_pixel t=%0t actual=%h expected=none", $time, nms_path);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.care) begin
                  checks++;
                  if (nms_path !== e.val) begin
                     failures++;
                     $display("[TB] FAIL nms_path t=%0t actual=%h expected=%h", $time, nms_path, e.val);
                  end
               end
            end
         end
      end
   end

   function automatic logic [15:0] px(input int r, input int c);
      if (r < 0 || c < 0) return 16'd0;
      return img[r][c];
   endfunction

   // Output (r,c) judges input pixel (r-1,c-1) against its two neighbours on the gradient line.
   function automatic logic [15:0] nms_ref(input int r, input int c);
      logic [15:0] cen, a, b;
      if (r == 0 || c == 0) return 16'd0;
      cen = img[r-1][c-1];
      case (cen[13:10])
         4'b0001: begin a = px(r-1, c-2); b = px(r-1, c);   end
         4'b0100: begin a = px(r,   c-1); b = px(r-2, c-1); end
         4'b0010: begin a = px(r,   c);   b = px(r-2, c-2); end
         4'b1000: begin a = px(r,   c-2); b = px(r-2, c);   end
         default: return 16'd0;
      endcase
      if (cen[9:0] == 10'd0) return 16'd0;
      if (cen[9:0] >= a[9:0] && cen[9:0] >= b[9:0]) return cen;
      return 16'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_const(input logic [15:0] ridge, input logic [15:0] other);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = (c == 2) ? ridge : other;
   endtask

   task automatic fill_diag(input logic [3:0] dir);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = 16'd0;
      img[2][2] = {2'b00, dir, 10'd300};
      img[3][1] = 16'd299;
      img[1][3] = 16'd299;
      img[3][3] = 16'd301;
      img[1][1] = 16'd301;
   endtask

   task automatic fill_rand();
      logic [3:0] dirs [6];
      dirs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0110};
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = {2'($urandom_range(0, 3)), dirs[$urandom_range(0, 5)],
                         10'($urandom_range(0, 12) * 80)};
   endtask

   task automatic send_line(input int r, input int npix, input bit gaps, input bit hs_with_de);
      if (!hs_with_de) begin
         hs = 1'b1;
         tick();
      end
      hs = 1'b1;
      for (int c = 0; c < npix; c++) begin
         if (gaps && c != 0) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) tick();
         end
         de = 1'b1;
         if (c < W) begin
            gp = img[r][c];
            q.push_back('{val: nms_ref(r, c), care: 1'b1});
         end else begin
            gp = 16'($urandom);
            q.push_back('{val: 16'd0, care: 1'b0});
         end
         tick();
         de = 1'b0;
         gp = 16'($urandom);
      end
      hs = 1'b0;
      tick();
      tick();
   endtask

   task automatic applyStimulus(input bit gaps, input int long_row, input int sim_row);
      vs = 1'b1;
      frame_on = 1'b1;
      tick();
      tick();
      for (int r = 0; r < H; r++)
         send_line(r, (r == long_row) ? 7 : W, gaps, r == sim_row);
      vs = 1'b0;
      repeat (4) tick();
   endtask

   task automatic checkOutput(input string name, input logic [18:0] actual, input logic [18:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic reset_mid_line();
      fill_rand();
      vs = 1'b1;
      frame_on = 1'b1;
      tick();
      hs = 1'b1;
      tick();
      for (int c = 0; c < 3; c++) begin
         de = 1'b1;
         gp = img[0][c];
         q.push_back('{val: nms_ref(0, c), care: 1'b1});
         tick();
      end
      de = 1'b1;
      gp = 16'hFFFF;
      rst_s = 1'b0;
      frame_on = 1'b0;
      q.delete();
      #1;
      checkOutput("reset_async_outputs", {nms_hs, nms_vs, nms_de, nms_path}, 19'd0);
      tick();
      checkOutput("reset_next_cycle", {nms_hs, nms_vs, nms_de, nms_path}, 19'd0);
      rst_s = 1'b1;
      for (int c = 0; c < 3; c++) begin
         de = 1'b1;
         gp = 16'h84C8;
         tick();
      end
      de = 1'b0;
      hs = 1'b0;
      tick();
      send_line(1, W, 1'b0, 1'b0);
      q.delete();
      repeat (4) tick();
      checkOutput("post_reset_quiet", {nms_hs, nms_vs, nms_de, nms_path}, 19'd0);
      vs = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      rst_s = 1'b0;
      hs = 1'b0; vs = 1'b0; de = 1'b0; gp = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state", {nms_hs, nms_vs, nms_de, nms_path}, 19'd0);
      rst_s = 1'b1;
      repeat (2) tick();

      fill_const(16'h84C8, 16'h8464);
      applyStimulus(1'b0, -1, -1);
      fill_const(16'h5096, 16'h5096);
      applyStimulus(1'b0, -1, 1);
      fill_diag(4'b1000);
      applyStimulus(1'b0, -1, -1);
      fill_diag(4'b0010);
      applyStimulus(1'b0, -1, -1);
      fill_rand();
      applyStimulus(1'b1, -1, 3);
      fill_rand();
      applyStimulus(1'b0, 1, -1);

      reset_mid_line();
      fill_rand();
      applyStimulus(1'b1, 2, 0);

      begin
         int waitc;
         waitc = 0;
         while (q.size() != 0 && waitc < 50) begin
            tick();
            waitc++;
         end
         checkOutput("scoreboard_drained", 19'(q.size()), 19'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
